// File: rtl/interrupt_controller_n.sv
// ---------------------------------------------------------------------------
// interrupt_controller_n
//
// Purpose:
//   Collects NUM_SRC interrupt sources, each edge- or level-sensitive, applies
//   per-source masking and a global enable, and picks the lowest-index
//   eligible source. The chosen source's index and vector address are
//   offered to the hazard control unit over a request / ack / done handshake.
//
// Ports:
//   clock        in   core clock, rising edge
//   nreset       in   asynchronous active-low reset
//   irq_src      in   raw source lines (synchronous to clock)
//   edge_sel     in   per source: 1 = rising-edge sensitive, 0 = level
//   control_reg  in   bit0 = global enable, bits 7:1 unused
//   mask_reg     in   per source: 1 = enabled
//   pend_clr     in   one-cycle software clear of edge pending bits
//   int_ack      in   hazard unit took the vector (one-cycle pulse)
//   int_done     in   ISR return retired (one-cycle pulse)
//   interrupt    out  request to the hazard unit
//   int_vec_addr out  vector address of the latched source
//   int_id       out  index of the latched source
//   pending      out  pending status of every source
//   in_service   out  high from ack until int_done
//   dbg_state    out  current handshake FSM state (debug visibility)
//
// Handshake: interrupt rises when a source is committed and stays high, with
// int_id / int_vec_addr frozen, until a one-cycle int_ack is seen. in_service
// then stays high until a one-cycle int_done. An int_ack that arrives while
// no request is outstanding, or an int_done while nothing is in service, is
// ignored.
// ---------------------------------------------------------------------------
module interrupt_controller_n #(
  parameter int              NUM_SRC    = 8,
  parameter int              ADDR_W     = 14,
  parameter logic [ADDR_W-1:0] VEC_BASE = 14'h0004,
  parameter int              VEC_STRIDE = 4,
  localparam int             ID_W       = $clog2(NUM_SRC)
) (
  input  logic               clock,
  input  logic               nreset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] edge_sel,
  input  logic [7:0]         control_reg,
  input  logic [NUM_SRC-1:0] mask_reg,
  input  logic [NUM_SRC-1:0] pend_clr,
  input  logic               int_ack,
  input  logic               int_done,
  output logic               interrupt,
  output logic [ADDR_W-1:0]  int_vec_addr,
  output logic [ID_W-1:0]    int_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               in_service,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_SRC-1:0] prev;
  logic [NUM_SRC-1:0] pend_e;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] eligible;
  logic               any_eligible;
  logic [ID_W-1:0]    winner;
  logic [ADDR_W-1:0]  winner_vec;
  logic               global_en;
  logic               unused_ctrl;

  assign global_en   = control_reg[0];
  assign unused_ctrl = ^control_reg[7:1];
  assign dbg_state   = state;

  // Rising-edge detect; prev resets to 0 so a source already high at reset
  // release counts as one edge.
  assign rise = irq_src & ~prev;

  // On ack, only the latched source's edge bit is consumed; level sources
  // have nothing latched to clear.
  always_comb begin
    ack_clr = '0;
    if (state == REQ && int_ack && edge_sel[int_id]) begin
      ack_clr[int_id] = 1'b1;
    end
  end

  // Level sources are never latched: they report the live line.
  assign pending      = (pend_e & edge_sel) | (irq_src & ~edge_sel);
  assign eligible     = pending & mask_reg & {NUM_SRC{global_en}};
  assign any_eligible = |eligible;

  // Fixed priority: scanning downward lets the lowest set index win.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = ID_W'(i);
      end
    end
  end

  // Vector wraps modulo 2^ADDR_W by virtue of the result width.
  assign winner_vec = VEC_BASE + (ADDR_W'(winner) * ADDR_W'(VEC_STRIDE));

  // Edge pending latch: a new edge beats any clear in the same cycle.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      prev   <= '0;
      pend_e <= '0;
    end else begin
      prev   <= irq_src;
      pend_e <= rise | (pend_e & ~(pend_clr | ack_clr));
    end
  end

  // Handshake FSM with registered outputs.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state        <= IDLE;
      interrupt    <= 1'b0;
      int_vec_addr <= '0;
      int_id       <= '0;
      in_service   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_eligible) begin
            int_id       <= winner;
            int_vec_addr <= winner_vec;
            interrupt    <= 1'b1;
            state        <= REQ;
          end
        end
        // Request is committed: id/vector stay frozen whatever happens to
        // masks, enable or the source line until the hazard unit acks.
        REQ: begin
          if (int_ack) begin
            interrupt  <= 1'b0;
            in_service <= 1'b1;
            state      <= SERVICE;
          end
        end
        // No nesting; new edges keep latching into pend_e meanwhile.
        SERVICE: begin
          if (int_done) begin
            in_service <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          interrupt <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller_n.sv
// ---------------------------------------------------------------------------
// Testbench for interrupt_controller_n (default parameters).
// Directed scenarios followed by randomized traffic, all compared cycle by
// cycle against a behavioural model that works on integer arrays.
// ---------------------------------------------------------------------------
module tb_interrupt_controller_n;

  localparam int N = 8;

  // clock / reset
  logic clock = 1'b0;
  logic nreset = 1'b0;
  always #5 clock = ~clock;

  // DUT signals
  logic [N-1:0]  irq_src = '0;
  logic [N-1:0]  edge_sel = 8'hFE;
  logic [7:0]    control_reg = 8'h01;
  logic [N-1:0]  mask_reg = 8'hFF;
  logic [N-1:0]  pend_clr = '0;
  logic          int_ack = 1'b0;
  logic          int_done = 1'b0;
  logic          interrupt;
  logic [13:0]   int_vec_addr;
  logic [2:0]    int_id;
  logic [N-1:0]  pending;
  logic          in_service;
  logic [1:0]    dbg_state;

  interrupt_controller_n dut (
    .clock        (clock),
    .nreset       (nreset),
    .irq_src      (irq_src),
    .edge_sel     (edge_sel),
    .control_reg  (control_reg),
    .mask_reg     (mask_reg),
    .pend_clr     (pend_clr),
    .int_ack      (int_ack),
    .int_done     (int_done),
    .interrupt    (interrupt),
    .int_vec_addr (int_vec_addr),
    .int_id       (int_id),
    .pending      (pending),
    .in_service   (in_service),
    .dbg_state    (dbg_state)
  );

  // ---------------- reference model ----------------
  // busy: 0 = free, 1 = request outstanding, 2 = being serviced
  int        m_busy;
  int        m_latched[N];  // edge occurrences not yet consumed
  int        m_last[N];     // line level seen at the previous edge
  int        m_id;
  int        m_req;
  int        m_svc;
  int        m_vec;

  int checks = 0;
  int passed = 0;

  function automatic void model_reset();
    m_busy = 0; m_id = 0; m_req = 0; m_svc = 0; m_vec = 0;
    for (int i = 0; i < N; i++) begin
      m_latched[i] = 0;
      m_last[i]    = 0;
    end
  endfunction

  function automatic int src_pending(int i);
    if (edge_sel[i]) return m_latched[i];
    return int'(irq_src[i]);
  endfunction

  function automatic logic [N-1:0] exp_pending();
    logic [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = (src_pending(i) != 0);
    return p;
  endfunction

  // Advance the model across one rising clock edge using pre-edge inputs.
  function automatic void model_edge();
    int pick;
    int consume;
    if (!nreset) begin
      model_reset();
      return;
    end
    pick = -1;
    if (control_reg[0]) begin
      for (int i = N - 1; i >= 0; i--)
        if (src_pending(i) != 0 && mask_reg[i]) pick = i;
    end
    consume = -1;
    if (m_busy == 0) begin
      if (pick >= 0) begin
        m_id = pick;
        m_vec = (4 + pick * 4) % 16384;
        m_req = 1;
        m_busy = 1;
      end
    end else if (m_busy == 1) begin
      if (int_ack) begin
        m_req = 0;
        m_svc = 1;
        m_busy = 2;
        if (edge_sel[m_id]) consume = m_id;
      end
    end else begin
      if (int_done) begin
        m_svc = 0;
        m_busy = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (irq_src[i] && m_last[i] == 0) m_latched[i] = 1;
      else if (pend_clr[i] || i == consume) m_latched[i] = 0;
      m_last[i] = int'(irq_src[i]);
    end
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".interrupt"}, 32'(interrupt), 32'(m_req));
    chk({tag, ".in_service"}, 32'(in_service), 32'(m_svc));
    chk({tag, ".pending"}, 32'(pending), 32'(exp_pending()));
    if (m_req != 0) begin
      chk({tag, ".int_id"}, 32'(int_id), 32'(m_id));
      chk({tag, ".int_vec_addr"}, 32'(int_vec_addr), 32'(m_vec));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic pulse_src(input logic [N-1:0] v, input string tag);
    irq_src = v;
    step(tag);
    irq_src = '0;
  endtask

  task automatic do_ack(input string tag);
    int_ack = 1'b1;
    step(tag);
    int_ack = 1'b0;
  endtask

  task automatic do_done(input string tag);
    int_done = 1'b1;
    step(tag);
    int_done = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #12;
    check_all("reset");
    chk("reset.int_vec_addr", 32'(int_vec_addr), 32'h0);
    chk("reset.int_id", 32'(int_id), 32'h0);
    @(posedge clock); #1;
    nreset = 1'b1;
    step("idle");

    // 1: single edge on src3, two-cycle latency, ack consumes it
    pulse_src(8'h08, "t1.edge");
    chk("t1.no_req_yet", 32'(interrupt), 32'h0);
    step("t1.req");
    chk("t1.id", 32'(int_id), 32'd3);
    chk("t1.vec", 32'(int_vec_addr), 32'h0010);
    do_ack("t1.ack");
    chk("t1.pend3", 32'(pending[3]), 32'h0);
    chk("t1.insvc", 32'(in_service), 32'h1);
    do_done("t1.done");

    // 2: simultaneous edges on src1 and src5, lowest index first
    pulse_src(8'h22, "t2.edge");
    step("t2.req1");
    chk("t2.vec1", 32'(int_vec_addr), 32'h0008);
    do_ack("t2.ack1");
    do_done("t2.done1");
    step("t2.req5");
    chk("t2.vec5", 32'(int_vec_addr), 32'h0018);
    do_ack("t2.ack5");
    do_done("t2.done5");

    // 3: masked source stays pending, served once unmasked
    mask_reg = 8'hFB;
    pulse_src(8'h04, "t3.edge");
    step("t3.masked");
    step("t3.masked2");
    chk("t3.pend2", 32'(pending[2]), 32'h1);
    mask_reg = 8'hFF;
    step("t3.unmask");
    chk("t3.id", 32'(int_id), 32'd2);
    do_ack("t3.ack");
    do_done("t3.done");

    // 4: level source held high re-requests; dropped -> silence
    irq_src = 8'h01;
    step("t4.req");
    do_ack("t4.ack");
    do_done("t4.done");
    step("t4.rereq");
    chk("t4.rereq_id", 32'(int_id), 32'd0);
    irq_src = 8'h00;
    do_ack("t4.ack2");
    do_done("t4.done2");
    step("t4.quiet1");
    step("t4.quiet2");
    chk("t4.none", 32'(interrupt), 32'h0);

    // 5: edge during service waits; set beats clear
    pulse_src(8'h40, "t5.edge6");
    step("t5.req6");
    do_ack("t5.ack6");
    pulse_src(8'h10, "t5.edge4");
    step("t5.svc1");
    step("t5.svc2");
    chk("t5.held", 32'(interrupt), 32'h0);
    irq_src = 8'h10;
    pend_clr = 8'h10;
    step("t5.set_vs_clr");
    irq_src = '0;
    pend_clr = '0;
    chk("t5.pend4", 32'(pending[4]), 32'h1);
    do_done("t5.done6");
    step("t5.req4");
    chk("t5.id4", 32'(int_id), 32'd4);
    do_ack("t5.ack4");
    do_done("t5.done4");

    // 6: async reset during REQ, then global disable
    pulse_src(8'h08, "t6.edge");
    step("t6.req");
    #3;
    nreset = 1'b0;
    #1;
    model_reset();
    check_all("t6.async");
    chk("t6.vec0", 32'(int_vec_addr), 32'h0);
    step("t6.held");
    nreset = 1'b1;
    control_reg = 8'hFE;  // reserved bits set, enable clear
    pulse_src(8'h02, "t6.dis_edge");
    step("t6.dis1");
    step("t6.dis2");
    chk("t6.blocked", 32'(interrupt), 32'h0);
    control_reg = 8'h01;
    step("t6.enable");
    chk("t6.id1", 32'(int_id), 32'd1);
    do_ack("t6.ack");
    do_done("t6.done");

    // randomized traffic
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc % 100 == 0) edge_sel = 8'($urandom_range(0, 255));
      irq_src     = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      mask_reg    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF;
      control_reg = {7'($urandom_range(0, 127)), ($urandom_range(0, 7) != 0)};
      pend_clr    = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      int_ack     = ($urandom_range(0, 2) == 0);
      int_done    = ($urandom_range(0, 2) == 0);
      step("rand");
    end
    int_ack = 1'b0;
    int_done = 1'b0;
    irq_src = '0;
    pend_clr = '0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
